n_bit_serial_subtractor: RTL and testbench
==========================================

# n_bit_serial_subtractor

Multi-cycle digit-serial integer subtractor computing `op1 - op2` over `BIT_NUM` bits, `CHUNK` bits per clock, with a propagated borrow chain held in a register between chunks. It complements the combinational ripple-carry adder in the ALU datapath. Area-critical paths such as the divider, address-bound checks and CSR counter compares use it where single-cycle full-width carry propagation is not affordable. Operands enter and results leave through valid/ready handshakes.

## Interface
- `BIT_NUM`, 64: operand and result width. Must be a multiple of `CHUNK`.
- `CHUNK`, 8: bits processed per cycle. Must be ≥1 and ≤`BIT_NUM`.
- `clk_i`  in  1  clock, rising edge.
- `arst_ni`  in  1  reset, asynchronous and active-low.
- `in_valid_i`  in  1  operands valid.
- `in_ready_o`  out  1  block can accept operands.
- `op1_i`  in  BIT_NUM  minuend.
- `op2_i`  in  BIT_NUM  subtrahend.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts result.
- `diff_o`  out  BIT_NUM  `op1 - op2` mod 2^BIT_NUM.
- `borrow_o`  out  1  high iff `op1 < op2` (unsigned).
- `overflow_o`  out  1  signed overflow of `op1 - op2`.

## Operation
- N = BIT_NUM/CHUNK. The FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - `in_ready_o`=1 and `out_valid_o`=0.
  - When `in_valid_i` is high, both operands are latched into internal registers, the chunk index is cleared to 0, the borrow register is cleared to 0, and the state moves to BUSY.
- **BUSY**
  - Each cycle computes chunk k as `op1[k] - op2[k] - borrow`.
  - The CHUNK-bit result is written into the diff register at slice k, and the borrow-out is registered.
  - After chunk N-1 the state moves to DONE. `in_ready_o`=0 throughout.
- **DONE**
  - `out_valid_o`=1; `diff_o`, `borrow_o` and `overflow_o` stay stable.
  - When `out_ready_i` is high, the state moves to IDLE.
  - A new operand pair is not accepted in the same cycle. `in_ready_o` rises the cycle after the output handshake.
- **Output values**
  - `borrow_o` is the final borrow-out of chunk N-1.
  - `overflow_o` is `(op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB])`.
- **Input sampling:** `op1_i`/`op2_i` are sampled only on the input handshake. Later changes to the inputs do not affect the result.
- **Reset:** an `arst_ni` assertion in any state, including mid-BUSY, forces IDLE immediately. The partial result is discarded.
- **Reset values:** `in_ready_o`=1, `out_valid_o`=0, `diff_o`=0, `borrow_o`=0, `overflow_o`=0.
- **N=1:** one BUSY cycle; the full-width subtract happens in that cycle.

## Timing
- Input handshake at edge E0 → BUSY from E0 to E(N). `out_valid_o` is asserted after edge E(N), giving a latency of N cycles.
- Throughput is one result per N+2 cycles at full consumer readiness: accept, N BUSY cycles, then the DONE handshake cycle.
- Outputs are registered. There is no combinational path from `op*_i` or `out_ready_i` to any output except that `in_ready_o` is a decode of state only.
- **Backpressure:** DONE holds indefinitely while `out_ready_i`=0, and outputs do not change.

## Configuration
- `SERIAL_SUB_OVERFLOW_EN`
  - Defined: `overflow_o` is computed as above and registered at entry to DONE.
  - Undefined: `overflow_o` is tied to 0 and the overflow logic is not synthesized. The port stays present so that instantiations are identical.

## Structure
- The shared ALU package holds:
  - the state enum (`serial_sub_state_e`: IDLE, BUSY, DONE);
  - a default-chunk localparam.
- The package does not hold width typedefs, which are parameter-dependent and stay local.
- One sub-module, `chunk_subtractor`:
  - combinational `CHUNK`-bit `a - b - borrow_in` → `diff`, `borrow_out`;
  - instantiated once and fed by an index-selected slice.
- Parameter legality (`BIT_NUM % CHUNK == 0`) is checked by elaboration-time assertion.

## Test plan
All scenarios use BIT_NUM=16, CHUNK=4 (N=4) unless noted.
- `0x1234 - 0x0234` → `diff_o`=0x1000, `borrow_o`=0, `overflow_o`=0, `out_valid_o` exactly 4 cycles after acceptance.
- `0x0000 - 0x0001` → `diff_o`=0xFFFF, `borrow_o`=1, `overflow_o`=0. The borrow ripples through all 4 chunks.
- `0x8000 - 0x0001` → `diff_o`=0x7FFF, `borrow_o`=0, `overflow_o`=1 with `SERIAL_SUB_OVERFLOW_EN` and 0 without.
- `out_ready_i` held low for 10 cycles in DONE, inputs toggled randomly → outputs stable, `in_ready_o`=0; handshake → IDLE next cycle.
- `arst_ni` low during BUSY chunk 2 → `out_valid_o`=0, `in_ready_o`=1 immediately; next op `0x00FF - 0x00FF` → `diff_o`=0x0000, `borrow_o`=0.
- Random back-to-back stream of 1000 pairs with random `out_ready_i`, repeated at CHUNK=16 (N=1) and CHUNK=1 (N=16) → every result matches the reference subtraction and no result is lost or duplicated.

Source files
------------

// File: rtl/n_bit_serial_subtractor_pkg.sv
// Shared ALU definitions for the digit-serial subtractor: FSM state type and default chunk width.
package n_bit_serial_subtractor_pkg;

    localparam int unsigned DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } serial_sub_state_e;

endpackage

// File: rtl/n_bit_serial_subtractor_if.sv
// Operand/result valid-ready bundle for the digit-serial subtractor.
interface n_bit_serial_subtractor_if #(
    parameter int unsigned BIT_NUM = 64
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [BIT_NUM-1:0] op1_i;
    logic [BIT_NUM-1:0] op2_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [BIT_NUM-1:0] diff_o;
    logic               borrow_o;
    logic               overflow_o;

    modport master (
        output in_valid_i, op1_i, op2_i, out_ready_i,
        input  in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o
    );

    modport slave (
        input  in_valid_i, op1_i, op2_i, out_ready_i,
        output in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o
    );
endinterface

// File: rtl/n_bit_serial_subtractor_chunk_subtractor.sv
// Combinational CHUNK-bit a - b - borrow_in with borrow-out.
module chunk_subtractor #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             borrow_in,
    output logic [CHUNK-1:0] diff,
    output logic             borrow_out
);
    logic [CHUNK:0] full;

    // The extra top bit goes to 1 exactly when a < b + borrow_in.
    assign full       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
    assign diff       = full[CHUNK-1:0];
    assign borrow_out = full[CHUNK];
endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Digit-serial op1 - op2, CHUNK bits per clock with a registered borrow chain.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module n_bit_serial_subtractor
    import n_bit_serial_subtractor_pkg::*;
#(
    parameter int unsigned BIT_NUM = 64,
    parameter int unsigned CHUNK   = DEFAULT_CHUNK
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    n_bit_serial_subtractor_if.slave   bus
);
    localparam int unsigned N     = BIT_NUM / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1 || CHUNK > BIT_NUM || (BIT_NUM % CHUNK) != 0) begin : g_bad_params
        $error("n_bit_serial_subtractor: BIT_NUM must be a non-zero multiple of CHUNK");
    end

    serial_sub_state_e  state_q, state_d;
    logic [BIT_NUM-1:0] op1_q, op2_q, diff_q;
    logic [IDX_W-1:0]   idx_q;
    logic               borrow_q;
    logic               last_chunk;
    logic [CHUNK-1:0]   chunk_a, chunk_b, chunk_diff;
    logic               chunk_borrow;

    assign last_chunk = (idx_q == IDX_W'(N - 1));
    assign chunk_a    = op1_q[idx_q * CHUNK +: CHUNK];
    assign chunk_b    = op2_q[idx_q * CHUNK +: CHUNK];

    chunk_subtractor #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a          (chunk_a),
        .b          (chunk_b),
        .borrow_in  (borrow_q),
        .diff       (chunk_diff),
        .borrow_out (chunk_borrow)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid_i) state_d = BUSY;
            BUSY:    if (last_chunk)     state_d = DONE;
            DONE:    if (bus.out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        op1_q    <= bus.op1_i;
                        op2_q    <= bus.op2_i;
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                    end
                end
                BUSY: begin
                    diff_q[idx_q * CHUNK +: CHUNK] <= chunk_diff;
                    borrow_q                      <= chunk_borrow;
                    if (!last_chunk) idx_q <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic overflow_q;

    // The last chunk holds the MSB, so its fresh diff bit decides overflow.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            overflow_q <= 1'b0;
        end else if (state_q == BUSY && last_chunk) begin
            overflow_q <= (op1_q[BIT_NUM-1] != op2_q[BIT_NUM-1]) &&
                          (chunk_diff[CHUNK-1] != op1_q[BIT_NUM-1]);
        end
    end

    assign bus.overflow_o = overflow_q;
`else
    assign bus.overflow_o = 1'b0;
`endif

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.diff_o      = diff_q;
    assign bus.borrow_o    = borrow_q;
endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Self-checking bench: directed cases on a CHUNK=4 instance, then random streams at CHUNK=4/16/1.
module tb_n_bit_serial_subtractor;
    localparam int unsigned W       = 16;
    localparam int unsigned NUM_OPS = 1000;

    logic clk = 1'b0;
    logic arst_ni;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic streams_go = 1'b0;
    logic [2:0] stream_done = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference {overflow, borrow, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        int          sd;
        logic        ovf;
        logic [W-1:0] d;
        d  = W'(int'(a) - int'(b));
        sd = int'($signed(a)) - int'($signed(b));
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf = (sd > 32767) || (sd < -32768);
`else
        ovf = 1'b0;
`endif
        return {ovf, (a < b), d};
    endfunction

    n_bit_serial_subtractor_if #(.BIT_NUM(W)) bus_dir ();

    n_bit_serial_subtractor #(
        .BIT_NUM(W),
        .CHUNK  (4)
    ) u_dir (
        .clk_i  (clk),
        .arst_ni(arst_ni),
        .bus    (bus_dir)
    );

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clk);
        bus_dir.in_valid_i = 1'b1;
        bus_dir.op1_i      = a;
        bus_dir.op2_i      = b;
        n = 0;
        while (!bus_dir.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_dir.in_ready_o) check("dir_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus_dir.in_valid_i = 1'b0;
        bus_dir.op1_i      = W'($urandom);
        bus_dir.op2_i      = W'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus_dir.out_valid_o) break;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        bus_dir.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus_dir.out_ready_i = 1'b0;
        check("idle_in_ready", 32'(bus_dir.in_ready_o), 1);
        check("idle_out_valid", 32'(bus_dir.out_valid_o), 0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        check(tag, {bus_dir.overflow_o, bus_dir.borrow_o, bus_dir.diff_o}, 32'(ref_sub(a, b)));
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_stream
        localparam int unsigned C = (g == 0) ? 4 : (g == 1) ? 16 : 1;

        n_bit_serial_subtractor_if #(.BIT_NUM(W)) s_bus ();

        n_bit_serial_subtractor #(
            .BIT_NUM(W),
            .CHUNK  (C)
        ) u_dut (
            .clk_i  (clk),
            .arst_ni(arst_ni),
            .bus    (s_bus)
        );

        logic [W+1:0] exp_q[$];

        initial begin : drv
            logic [W-1:0] a, b;
            int n;
            s_bus.in_valid_i = 1'b0;
            s_bus.op1_i      = '0;
            s_bus.op2_i      = '0;
            wait (streams_go);
            for (int i = 0; i < NUM_OPS; i++) begin
                @(negedge clk);
                a = W'($urandom);
                b = W'($urandom);
                case ($urandom_range(0, 7))
                    0: b = a;
                    1: a = '0;
                    2: b = '1;
                    default: ;
                endcase
                s_bus.in_valid_i = 1'b1;
                s_bus.op1_i      = a;
                s_bus.op2_i      = b;
                n = 0;
                while (!s_bus.in_ready_o && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (!s_bus.in_ready_o) begin
                    check($sformatf("stream%0d_accept_timeout", C), 0, 1);
                    break;
                end
                exp_q.push_back(ref_sub(a, b));
                @(posedge clk);
                #1;
                s_bus.in_valid_i = 1'b0;
                s_bus.op1_i      = W'($urandom);
                s_bus.op2_i      = W'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            s_bus.in_valid_i = 1'b0;
        end

        initial begin : mon
            int rx, cyc;
            logic [W+1:0] e;
            s_bus.out_ready_i = 1'b0;
            rx  = 0;
            cyc = 0;
            wait (streams_go);
            while (rx < NUM_OPS && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                s_bus.out_ready_i = ($urandom_range(0, 3) != 0);
                if (s_bus.out_valid_o && s_bus.out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("stream%0d_spurious", C), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("stream%0d_result", C),
                              {s_bus.overflow_o, s_bus.borrow_o, s_bus.diff_o}, 32'(e));
                    end
                    rx++;
                end
            end
            @(negedge clk);
            s_bus.out_ready_i = 1'b0;
            check($sformatf("stream%0d_count", C), rx, NUM_OPS);
            check($sformatf("stream%0d_leftover", C), exp_q.size(), 0);
            stream_done[g] = 1'b1;
        end
    end

    initial begin
        int lat;
        int n;
        arst_ni             = 1'b0;
        bus_dir.in_valid_i  = 1'b0;
        bus_dir.out_ready_i = 1'b0;
        bus_dir.op1_i       = '0;
        bus_dir.op2_i       = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus_dir.in_ready_o), 1);
        check("rst_out_valid", 32'(bus_dir.out_valid_o), 0);
        check("rst_outputs", {bus_dir.overflow_o, bus_dir.borrow_o, bus_dir.diff_o}, 0);
        arst_ni = 1'b1;

        start_op(16'h1234, 16'h0234);
        check("busy_in_ready", 32'(bus_dir.in_ready_o), 0);
        wait_done(lat);
        check("latency", lat, 4);
        check_result("sub_1234_0234", 16'h1234, 16'h0234);
        check("diff_1000", 32'(bus_dir.diff_o), 32'h1000);
        finish_op();

        start_op(16'h0000, 16'h0001);
        wait_done(lat);
        check("diff_ffff", {bus_dir.borrow_o, bus_dir.diff_o}, 32'h1FFFF);
        check_result("sub_0000_0001", 16'h0000, 16'h0001);
        finish_op();

        start_op(16'h8000, 16'h0001);
        wait_done(lat);
        check("diff_7fff", {bus_dir.borrow_o, bus_dir.diff_o}, 32'h07FFF);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("ovf_8000_0001", 32'(bus_dir.overflow_o), 1);
`else
        check("ovf_8000_0001", 32'(bus_dir.overflow_o), 0);
`endif
        finish_op();

        // Backpressure: DONE must hold while inputs churn.
        start_op(16'hA5C3, 16'h3C5A);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_dir.in_valid_i = 1'($urandom);
            bus_dir.op1_i      = W'($urandom);
            bus_dir.op2_i      = W'($urandom);
            check_result("bp_hold", 16'hA5C3, 16'h3C5A);
            check("bp_in_ready", 32'(bus_dir.in_ready_o), 0);
            check("bp_out_valid", 32'(bus_dir.out_valid_o), 1);
        end
        @(negedge clk);
        bus_dir.in_valid_i = 1'b0;
        finish_op();

        // Reset during chunk 2 of BUSY.
        start_op(16'h5555, 16'h1111);
        @(posedge clk);
        @(posedge clk);
        #2;
        arst_ni = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus_dir.out_valid_o), 0);
        check("midrst_in_ready", 32'(bus_dir.in_ready_o), 1);
        check("midrst_diff", 32'(bus_dir.diff_o), 0);
        #1;
        arst_ni = 1'b1;
        start_op(16'h00FF, 16'h00FF);
        wait_done(lat);
        check("after_rst_latency", lat, 4);
        check("after_rst_result", {bus_dir.overflow_o, bus_dir.borrow_o, bus_dir.diff_o}, 0);
        finish_op();

        streams_go = 1'b1;
        n = 0;
        while (stream_done != 3'b111 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("streams_complete", 32'(stream_done), 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
